// File: rtl/uart_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_write_arbiter
// Brief    : Packet-level round-robin arbiter for the UART TX FIFO write port.
//            Keyboard bytes (requester 0) are buffered because that path has no
//            backpressure. Optional lock watchdog: define UART_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module uart_fifo_write_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int DATA_W    = 8,
   parameter int KBD_DEPTH = 8,
   parameter int TIMEOUT   = 255
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        kbd_write,
   input  logic [DATA_W-1:0]           kbd_data,
   output logic                        kbd_overflow,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   input  logic [NUM_REQ-1:0]          req_last,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic                        fifo_full,
   output logic                        fifo_write,
   output logic [DATA_W-1:0]           fifo_data,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id,
   output logic                        busy,
   output logic                        timeout_err
);

   localparam int c_ID_W  = $clog2(NUM_REQ);
   localparam int c_PTR_W = $clog2(KBD_DEPTH);

   localparam logic [0:0] c_IDLE = 1'b0;
   localparam logic [0:0] c_LOCK = 1'b1;

   logic [0:0]        r_state;
   logic [0:0]        w_state_nxt;
   logic [c_ID_W-1:0] r_grant;
   logic [c_ID_W-1:0] r_rr;
   logic [c_ID_W-1:0] w_pick;
   logic [c_ID_W-1:0] w_cand;
   logic              w_found;

   logic [DATA_W-1:0] r_buf [KBD_DEPTH];
   logic [c_PTR_W:0]  r_wptr;
   logic [c_PTR_W:0]  r_rptr;
   logic              r_overflow;
   logic              w_empty;
   logic              w_full;
   logic              w_push;
   logic              w_pop;

   logic [DATA_W-1:0] w_req_byte [NUM_REQ];
   logic [NUM_REQ-1:0] w_pending;
   logic              w_own_valid;
   logic              w_own_last;
   logic [DATA_W-1:0] w_own_data;
   logic              w_xfer;
   logic              w_timeout;
   logic              w_unused;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign w_req_byte[gi] = req_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Slot 0 of the requester bus belongs to the keyboard, which uses kbd_* instead.
   assign w_unused = ^{req_valid[0], req_last[0], w_req_byte[0], (TIMEOUT == 0)};

   // ---------------- keyboard buffer ----------------
   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[c_PTR_W] != r_rptr[c_PTR_W]) &&
                    (r_wptr[c_PTR_W-1:0] == r_rptr[c_PTR_W-1:0]);
   assign w_pop   = w_xfer && (r_grant == '0);
   assign w_push  = kbd_write && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_buf[r_wptr[c_PTR_W-1:0]] <= kbd_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         if (kbd_write && !w_push) r_overflow <= 1'b1;
      end
   end

   // ---------------- arbitration ----------------
   assign w_pending = {req_valid[NUM_REQ-1:1], ~w_empty};

   // First pending index strictly after the rr pointer, circularly.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_cand  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand = c_ID_W'((int'(r_rr) + k) % NUM_REQ);
         if (!w_found && w_pending[w_cand]) begin
            w_found = 1'b1;
            w_pick  = w_cand;
         end
      end
   end

   always_comb begin
      w_own_valid = ~w_empty;
      w_own_last  = 1'b1;
      w_own_data  = r_buf[r_rptr[c_PTR_W-1:0]];
      if (r_grant != '0) begin
         w_own_valid = req_valid[r_grant];
         w_own_last  = req_last[r_grant];
         w_own_data  = w_req_byte[r_grant];
      end
   end

   assign w_xfer = (r_state == c_LOCK) && w_own_valid && !fifo_full;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int c_CNT_W = $clog2(TIMEOUT + 1);

   logic [c_CNT_W-1:0] r_cnt;

   // fifo_full stalls with a byte present are not owner idleness, so they hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if ((r_state == c_IDLE) || w_xfer) begin
         r_cnt <= '0;
      end else if (!w_own_valid) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign w_timeout = (r_state == c_LOCK) && !w_own_valid &&
                      (r_cnt == c_CNT_W'(TIMEOUT - 1));
`else
   assign w_timeout = 1'b0;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_IDLE;
         r_grant <= '0;
         r_rr    <= c_ID_W'(NUM_REQ - 1);
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == c_IDLE) && w_found) begin
            r_grant <= w_pick;
            r_rr    <= w_pick;
         end
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE: if (w_found) w_state_nxt = c_LOCK;
         c_LOCK: if ((w_xfer && w_own_last) || w_timeout) w_state_nxt = c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      fifo_write  = w_xfer;
      fifo_data   = w_xfer ? w_own_data : '0;
      req_ready   = '0;
      if (w_xfer && (r_grant != '0)) req_ready[r_grant] = 1'b1;
      busy        = (r_state == c_LOCK);
      timeout_err = w_timeout;
   end

   assign grant_id     = r_grant;
   assign kbd_overflow = r_overflow;

endmodule
`default_nettype wire
